// File: rtl/sqrt_seq_ctrl.sv
// sqrt_seq_ctrl: sequencing FSM for the odd-number subtraction square root.
// Drives the remainder / odd / root register controls of the datapath and
// reads back the remainder >= odd flag. Every control output is a Moore
// decode of the state.
// Optional feature: define SQRT_SEQ_CTRL_ABORT_EN to add the abort port,
// which cancels an operation in INIT, CMP or STEP.
module sqrt_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 2 ** (WIDTH / 2)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              ge,
`ifdef SQRT_SEQ_CTRL_ABORT_EN
  input  logic                              abort,
`endif
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              rem_ld,
  output logic                              rem_en,
  output logic                              odd_set,
  output logic                              odd_en,
  output logic                              root_rst,
  output logic                              root_en,
  output logic                              out_en,
  output logic [$clog2(MAX_ITER+1)-1:0]     iter
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CMP  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          err_q, err_d;

  // State, iteration counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and Moore decode of the datapath controls.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    err_d    = err_q;
    rem_ld   = 1'b0;
    rem_en   = 1'b0;
    odd_set  = 1'b0;
    odd_en   = 1'b0;
    root_rst = 1'b0;
    root_en  = 1'b0;
    out_en   = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A new operation wipes the previous count and error.
        if (start) begin
          state_d = S_INIT;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        rem_ld   = 1'b1;
        odd_set  = 1'b1;
        root_rst = 1'b1;
        state_d  = S_CMP;
      end
      S_CMP: begin
        // ge is only trusted here; it reflects registers settled by INIT/STEP.
        if (!ge) begin
          state_d = S_DONE;
        end else if (iter_q < ITER_MAX) begin
          state_d = S_STEP;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_STEP: begin
        rem_en  = 1'b1;
        odd_en  = 1'b1;
        root_en = 1'b1;
        // Saturate rather than wrap; CMP already bounds entry here.
        if (iter_q < ITER_MAX) begin
          iter_d = iter_q + IW'(1);
        end
        state_d = S_CMP;
      end
      S_DONE: begin
        out_en  = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SQRT_SEQ_CTRL_ABORT_EN
    // Abort cancels mid-operation but leaves iter and err as they were.
    if (abort && (state_q == S_INIT || state_q == S_CMP || state_q == S_STEP)) begin
      state_d = S_IDLE;
      iter_d  = iter_q;
      err_d   = err_q;
    end
`endif
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;
  assign iter = iter_q;

endmodule
